// File: rtl/div_unit_if.sv
// Request, result and divider-side signals of the divide/remainder sequencing stage.
// The requester/divider side uses master and div_unit uses slave.
interface div_unit_if;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic         in_word;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         div_req;
    logic [63:0]  div_a;
    logic [63:0]  div_b;
    logic [127:0] div_c;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    modport master (
        output in_valid, in_op, in_word, in_a, in_b, out_ready, div_c,
        input  in_ready, div_req, div_a, div_b, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b, out_ready, div_c,
        output in_ready, div_req, div_a, div_b, out_valid, out_data
    );
endinterface

// File: rtl/div_unit.sv
// RV64M divide/remainder sequencer wrapped around a fixed-latency unsigned divider.
// It prepares the operand magnitudes, resolves the special cases, and sign-corrects the result.
module div_unit #(
    parameter int DIV_LAT = 65
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     flush,
    div_unit_if.slave bus
);

    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          op_rem;
    logic          word_r;
    logic          sa_r;
    logic          sb_r;

    logic          is_signed;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   mag_a;
    logic [63:0]   mag_b;
    logic          sa;
    logic          sb;
    logic          b_zero;
    logic          ovf;
    logic          special;
    logic [63:0]   special_data;
    logic [63:0]   q_fix;
    logic [63:0]   r_fix;
    logic [63:0]   norm_data;
    logic          accept;
    logic          busy_last;

    function automatic logic [63:0] wext(input logic [63:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    assign is_signed = ~bus.in_op[0];

    // The special results come straight from the extended operands, so the divider is skipped.
    always_comb begin
        if (bus.in_word) begin
            ext_a = is_signed ? {{32{bus.in_a[31]}}, bus.in_a[31:0]} : {32'b0, bus.in_a[31:0]};
            ext_b = is_signed ? {{32{bus.in_b[31]}}, bus.in_b[31:0]} : {32'b0, bus.in_b[31:0]};
        end else begin
            ext_a = bus.in_a;
            ext_b = bus.in_b;
        end
        sa      = is_signed & ext_a[63];
        sb      = is_signed & ext_b[63];
        mag_a   = sa ? (~ext_a + 64'd1) : ext_a;
        mag_b   = sb ? (~ext_b + 64'd1) : ext_b;
        b_zero  = (ext_b == 64'd0);
        ovf     = is_signed && (ext_b == {64{1'b1}}) &&
                  (ext_a == (bus.in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special = b_zero | ovf;
        if (bus.in_op[1]) begin
            special_data = b_zero ? ext_a : 64'd0;
        end else begin
            special_data = b_zero ? {64{1'b1}} : ext_a;
        end
        special_data = wext(special_data, bus.in_word);
    end

    always_comb begin
        q_fix     = (sa_r ^ sb_r) ? (~bus.div_c[63:0] + 64'd1) : bus.div_c[63:0];
        r_fix     = sa_r ? (~bus.div_c[127:64] + 64'd1) : bus.div_c[127:64];
        norm_data = wext(op_rem ? r_fix : q_fix, word_r);
    end

    assign accept      = (state == IDLE) && bus.in_valid && !flush;
    assign busy_last   = (state == BUSY) && (cnt == CW'(1));
    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = special ? DONE : BUSY;
            BUSY:    if (busy_last) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // div_req and out_valid follow the next state, so flush and accept take effect at the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt           <= '0;
            op_rem        <= 1'b0;
            word_r        <= 1'b0;
            sa_r          <= 1'b0;
            sb_r          <= 1'b0;
            bus.div_req   <= 1'b0;
            bus.div_a     <= 64'd0;
            bus.div_b     <= 64'd0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 64'd0;
        end else begin
            bus.div_req   <= (next_state == BUSY);
            bus.out_valid <= (next_state == DONE);
            if (accept) begin
                op_rem    <= bus.in_op[1];
                word_r    <= bus.in_word;
                sa_r      <= sa;
                sb_r      <= sb;
                bus.div_a <= mag_a;
                bus.div_b <= mag_b;
                cnt       <= CW'(DIV_LAT);
                if (special) begin
                    bus.out_data <= special_data;
                end
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
                if (busy_last && !flush) begin
                    bus.out_data <= norm_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV64M cases, flush/reset aborts and random requests.
// The bench acts as the requester, the consumer and the ideal fixed-latency divider.
module tb_div_unit;

    localparam int DIV_LAT = 65;

    logic clk;
    logic resetn;
    logic flush;
    int   n_checks;
    int   n_fail;

    div_unit_if bus ();

    div_unit #(.DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Ideal divider; a junk pattern is driven whenever no request is pending.
    assign bus.div_c = (bus.div_req && bus.div_b != 64'd0) ?
                       {bus.div_a % bus.div_b, bus.div_a / bus.div_b} :
                       128'hDEAD_BEEF_0BAD_F00D_5A5A_A5A5_1234_5678;

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic              is_rem;
        logic              sgn;
        int                a32s, b32s;
        int unsigned       a32u, b32u;
        longint            a64s, b64s;
        longint unsigned   a64u, b64u;
        logic [31:0]       r32;
        logic [63:0]       r64;
        is_rem = op[1];
        sgn    = !op[0];
        if (w) begin
            if (sgn) begin
                a32s = a[31:0];
                b32s = b[31:0];
                if (b32s == 0)                              r32 = is_rem ? a32s : 32'hFFFF_FFFF;
                else if (a32s == 32'sh8000_0000 && b32s == -1) r32 = is_rem ? 32'd0 : a32s;
                else                                        r32 = is_rem ? a32s % b32s : a32s / b32s;
            end else begin
                a32u = a[31:0];
                b32u = b[31:0];
                if (b32u == 0) r32 = is_rem ? a32u : 32'hFFFF_FFFF;
                else           r32 = is_rem ? a32u % b32u : a32u / b32u;
            end
            return {{32{r32[31]}}, r32};
        end
        if (sgn) begin
            a64s = a;
            b64s = b;
            if (b64s == 0)                                         r64 = is_rem ? a64s : {64{1'b1}};
            else if (a64s == 64'sh8000_0000_0000_0000 && b64s == -1) r64 = is_rem ? 64'd0 : a64s;
            else                                                   r64 = is_rem ? a64s % b64s : a64s / b64s;
        end else begin
            a64u = a;
            b64u = b;
            if (b64u == 0) r64 = is_rem ? a64u : {64{1'b1}};
            else           r64 = is_rem ? a64u % b64u : a64u / b64u;
        end
        return r64;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        end
        return (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}});
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_request(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_word  = w;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // One full transaction: accept, latency/div_req accounting, back-pressure, then out handshake.
    task automatic apply_stimulus(input logic [1:0] op, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, input int hold, input logic [63:0] exp);
        bit spec;
        int lat;
        int reqs;
        spec = is_special(op, w, a, b);
        @(negedge clk);
        check_output("in_ready_before", 64'(bus.in_ready), 64'd1);
        start_request(op, w, a, b);
        lat  = 0;
        reqs = 0;
        for (int k = 1; k <= DIV_LAT + 20; k++) begin
            @(negedge clk);
            if (bus.div_req) reqs++;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        check_output("latency", 64'(lat), spec ? 64'd1 : 64'(DIV_LAT + 1));
        check_output("div_req_cycles", 64'(reqs), spec ? 64'd0 : 64'(DIV_LAT));
        check_output("out_data", bus.out_data, exp);
        check_output("in_ready_done", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_output("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check_output("hold_out_data", bus.out_data, exp);
            check_output("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_output("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
        check_output("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic        r_w;
        logic [63:0] r_a;
        logic [63:0] r_b;
        int          seen;

        n_checks      = 0;
        n_fail        = 0;
        clk           = 1'b0;
        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_word   = 1'b0;
        bus.in_a      = 64'd0;
        bus.in_b      = 64'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_div_req", 64'(bus.div_req), 64'd0);
        check_output("rst_out_data", bus.out_data, 64'd0);
        check_output("rst_div_a", bus.div_a, 64'd0);
        check_output("rst_div_b", bus.div_b, 64'd0);
        check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);
        resetn = 1'b1;

        $display("[TB] directed cases");
        apply_stimulus(2'd1, 1'b0, 64'd100, 64'd7, 0, 64'd14);
        apply_stimulus(2'd3, 1'b0, 64'd100, 64'd7, 0, 64'd2);
        apply_stimulus(2'd0, 1'b0, -64'sd7, 64'd2, 0, -64'sd3);
        apply_stimulus(2'd2, 1'b0, -64'sd7, 64'd2, 0, -64'sd1);
        apply_stimulus(2'd0, 1'b0, 64'd7, -64'sd2, 0, -64'sd3);
        apply_stimulus(2'd2, 1'b0, 64'd7, -64'sd2, 0, 64'd1);
        apply_stimulus(2'd1, 1'b0, 64'd12345, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus(2'd2, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 0, 64'hFFFF_FFFF_8000_0005);
        apply_stimulus(2'd0, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 64'h8000_0000_0000_0000);
        apply_stimulus(2'd2, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 64'd0);
        apply_stimulus(2'd0, 1'b1, 64'h0000_0000_8000_0000, {64{1'b1}}, 0, 64'hFFFF_FFFF_8000_0000);
        apply_stimulus(2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 10, 64'hFFFF_FFFF_FFFF_FFFE);

        $display("[TB] flush mid-BUSY");
        start_request(2'd1, 1'b0, 64'd100, 64'd7);
        repeat (30) @(negedge clk);
        check_output("busy_div_req", 64'(bus.div_req), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_output("flush_div_req", 64'(bus.div_req), 64'd0);
        check_output("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("flush_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < DIV_LAT + 10; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.div_req) seen++;
        end
        check_output("flush_no_result", 64'(seen), 64'd0);

        $display("[TB] flush with in_valid in IDLE");
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check_output("flush_idle_div_req", 64'(bus.div_req), 64'd0);
        check_output("flush_idle_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] reset mid-BUSY");
        start_request(2'd0, 1'b0, 64'd1000, 64'd3);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_output("areset_div_req", 64'(bus.div_req), 64'd0);
        check_output("areset_in_ready", 64'(bus.in_ready), 64'd1);
        check_output("areset_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(2'd3, 1'b0, 64'd100, 64'd7, 2, 64'd2);

        $display("[TB] random requests");
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_w  = 1'($urandom_range(0, 1));
            r_a  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       r_b = 64'd0;
                1:       r_b = {64{1'b1}};
                2:       r_b = 64'($urandom_range(1, 1000));
                3:       r_b = {32'd0, $urandom};
                default: r_b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) begin
                r_a = r_w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            end
            apply_stimulus(r_op, r_w, r_a, r_b, int'($urandom_range(0, 3)),
                           ref_result(r_op, r_w, r_a, r_b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Sequencing and sign-handling stage wrapped around the 64-bit unsigned iterative divider in the execute stage. It accepts RV64M divide and remainder requests (DIV/DIVU/REM/REMU and their W forms) through a valid/ready handshake. It converts the operands to unsigned magnitudes, holds the divider request for the fixed divider latency, and captures the raw `{remainder, quotient}`. It then applies sign correction, the RISC-V divide-by-zero and overflow rules, and W-form sign extension before presenting the result to writeback.

## Interface
- `DIV_LAT`, 65: cycles `div_req` is held high before `div_c` is sampled.
- `clk` input 1: clock, all state on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush; abandons any operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `in_op` input 2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `in_word` input 1: W form; only bits [31:0] of the operands are used.
- `in_a` input 64: dividend.
- `in_b` input 64: divisor.
- `div_req` output 1: valid to the divider; held high for the whole run.
- `div_a` output 64: unsigned dividend magnitude to the divider.
- `div_b` output 64: unsigned divisor magnitude to the divider.
- `div_c` input 128: divider result, `{remainder, quotient}`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 64: final result.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Reset:** `resetn` low puts the unit in IDLE and clears the counter and all registers. `out_valid`, `div_req`, `out_data`, `div_a` and `div_b` are all 0.
- **Accept:** on `in_valid & in_ready`, register `op`, `word`, the sign flags and the magnitudes.
- **Operand preparation, W form:** take bits [31:0] of each operand. Sign-extend them for signed ops and zero-extend them for unsigned ops.
- **Operand preparation, signed:** `sa = a[63]`, `sb = b[63]` after extension. Each magnitude is the two's-complement absolute value.
- **Operand preparation, unsigned:** `sa = sb = 0` and the magnitude is the extended value.
- **Special cases** (decided at accept, divider not started, go straight to DONE):
  - `b == 0`: quotient is all ones (64'hFFFF_FFFF_FFFF_FFFF). Remainder is the extended `a`.
  - Signed op with `a` = most negative value and `b = -1`: quotient is `a`, remainder is 0. Most negative is 64'h8000_0000_0000_0000, or 32'h8000_0000 in the W form.
  - The comparison uses the extended operand width: 64 bits, or 32 bits for W.
- **Normal path:** go to BUSY with counter = `DIV_LAT`.
  - `div_req` = 1 throughout BUSY. `div_a` and `div_b` hold the registered magnitudes and are stable from the accept edge onward.
  - The counter decrements every BUSY cycle. In the BUSY cycle where the counter equals 1, sample `div_c` into the result register and go to DONE.
  - `div_req` falls at the same edge, which re-arms the divider.
- **Sign correction:** negate the quotient if `sa ^ sb`. Negate the remainder if `sa`. Both use 64-bit two's complement, modulo 2^64.
- **Result selection:** DIV/DIVU select the quotient; REM/REMU select the remainder.
- **W form output:** sign-extend bit 31 of the selected value to 64 bits, for both signed and unsigned ops.
- **DONE:** `out_valid` = 1 with `out_data` stable. On `out_ready` the unit returns to IDLE at the next edge. There is no back-to-back accept in the same cycle.
- **Flush:** in any state, the next edge enters IDLE and `div_req` = 0. `out_valid` is 0 from that edge, and no result is produced for the flushed request. If `flush` and `in_valid` are both high in IDLE, the request is not accepted.
- **Reset mid-operation:** an asynchronous return to IDLE and `div_req` drops immediately.

## Timing
- Request accepted at edge T.
- **Normal path:** BUSY for cycles T+1 through T+`DIV_LAT`. `out_valid` first high in cycle T+`DIV_LAT`+1, which is 66 cycles after accept with the default.
- **Special case:** `out_valid` high in cycle T+1.
- **Back-pressure:** `out_valid` and `out_data` are held indefinitely while `out_ready` = 0.
- **Throughput:** at most one request in flight. `in_ready` is low from T+1 until the edge after the out handshake.
- **Registered outputs:** all outputs are registered except `in_ready`, which decodes the state register.

## Test plan
- **DIVU, REMU:** `a=100`, `b=7` -> quotient 14 and remainder 2. `out_valid` exactly `DIV_LAT`+1 cycles after accept, and `div_req` high for exactly `DIV_LAT` cycles.
- **DIV, REM:** `a=-7`, `b=2` -> -3 and -1. With `a=7`, `b=-2` -> -3 and 1.
- **Divide by zero:** DIVU with `b=0` -> 64'hFFFF_FFFF_FFFF_FFFF. REMW with `a=32'h8000_0005`, `b=0` -> 64'hFFFF_FFFF_8000_0005. Both give `out_valid` at T+1 with `div_req` never high.
- **Signed overflow:** DIV with `a`=64'h8000_0000_0000_0000 and `b=-1` -> `a`, and REM of the same -> 0. DIVW with `a=32'h8000_0000`, `b=-1` -> 64'hFFFF_FFFF_8000_0000.
- **Back-pressure:** hold `out_ready` = 0 for 10 cycles -> `out_data` stable and `in_ready` low. A DIVUW with `a=32'hFFFF_FFFE`, `b=1` -> 64'hFFFF_FFFF_FFFF_FFFE.
- **Abort:** `flush` at BUSY cycle 30, then `resetn` low mid-BUSY on a second request -> next edge IDLE (immediately, for reset), `div_req` = 0, no `out_valid`. A new request then completes correctly.
